// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: walks the PC through instruction memory with a req/ready
// handshake and hands each word to the IR stage with a one-cycle EN load strobe.
module instruction_fetch_unit #(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}},
  parameter int                PC_STEP  = 1
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              Run,
  input  logic              Stall,
  input  logic              Redirect,
  input  logic [ADDR_W-1:0] Target,
  output logic              MemReq,
  output logic [ADDR_W-1:0] MemAddr,
  input  logic              MemRdy,
  input  logic [15:0]       MemData,
  output logic [15:0]       Instruction,
  output logic              EN,
  output logic [ADDR_W-1:0] IssuePC,
  output logic              Busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

  state_t            state_r;
  state_t            state_s;
  logic [ADDR_W-1:0] pc_r;
  logic [15:0]       instr_r;
  logic [ADDR_W-1:0] issue_pc_r;
  logic              capture_s;
  logic              en_s;

  // Next-state and strobe decode; Redirect overrides every other condition.
  always_comb begin
    state_s   = state_r;
    capture_s = 1'b0;
    en_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (Run) begin
          state_s = FETCH;
        end else begin
          state_s = IDLE;
        end
      end
      FETCH: begin
        if (Redirect) begin
          state_s = FETCH;
        end else if (MemRdy) begin
          capture_s = 1'b1;
          state_s   = ISSUE;
        end else begin
          state_s = FETCH;
        end
      end
      ISSUE: begin
        if (Redirect || !Stall) begin
          en_s    = !Redirect;
          state_s = Run ? FETCH : IDLE;
        end else begin
          state_s = ISSUE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, PC and captured-instruction registers.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_r    <= IDLE;
      pc_r       <= RESET_PC;
      instr_r    <= 16'h0000;
      issue_pc_r <= RESET_PC;
    end else begin
      state_r <= state_s;
      if (Redirect) begin
        pc_r <= Target;
      end else if (capture_s) begin
        pc_r <= pc_r + STEP;  // wraps modulo 2^ADDR_W
      end
      if (capture_s) begin
        instr_r    <= MemData;
        issue_pc_r <= pc_r;
      end
    end
  end

  assign MemAddr     = pc_r;
  assign MemReq      = (state_r == FETCH);
  assign Busy        = (state_r != IDLE);
  assign EN          = en_s;
  assign Instruction = instr_r;
  assign IssuePC     = issue_pc_r;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: directed stimulus pushes expected issues,
// a negedge monitor pops and compares on every EN strobe.
module tb_instruction_fetch_unit;

  logic        CLK;
  logic        Reset;
  logic        Run;
  logic        Stall;
  logic        Redirect;
  logic [15:0] Target;
  logic        MemReq;
  logic [15:0] MemAddr;
  logic        MemRdy;
  logic [15:0] MemData;
  logic [15:0] Instruction;
  logic        EN;
  logic [15:0] IssuePC;
  logic        Busy;

  int          vectors;
  int          miscompares;
  int          lat;
  int          wait_cnt;
  logic        use_alt;
  logic [15:0] alt_data;
  logic [31:0] sb_q[$];

  instruction_fetch_unit #(
    .ADDR_W  (16),
    .RESET_PC(16'h0000),
    .PC_STEP (1)
  ) dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .Run        (Run),
    .Stall      (Stall),
    .Redirect   (Redirect),
    .Target     (Target),
    .MemReq     (MemReq),
    .MemAddr    (MemAddr),
    .MemRdy     (MemRdy),
    .MemData    (MemData),
    .Instruction(Instruction),
    .EN         (EN),
    .IssuePC    (IssuePC),
    .Busy       (Busy)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (a == 16'h0000) return 16'h1234;
    else if (a == 16'h0001) return 16'hA5C3;
    else return a ^ 16'hC0DE;
  endfunction

  // Memory model: ready after 'lat' wait cycles, data combinational on address
  assign MemRdy  = MemReq && (wait_cnt >= lat);
  assign MemData = use_alt ? alt_data : mem_word(MemAddr);

  always @(posedge CLK or posedge Reset) begin
    if (Reset) wait_cnt <= 0;
    else if (MemReq && !MemRdy) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic sample();
    @(negedge CLK);
  endtask

  task automatic push(input logic [15:0] ins, input logic [15:0] pc);
    sb_q.push_back({ins, pc});
  endtask

  // Monitor: every EN strobe must match the oldest expected issue
  always @(negedge CLK) begin
    if (EN === 1'b1) begin
      logic [31:0] e;
      vectors++;
      if (sb_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_en: got instr %h pc %h expected no strobe at %0t",
                 Instruction, IssuePC, $time);
      end else begin
        e = sb_q.pop_front();
        if ({Instruction, IssuePC} !== e) begin
          miscompares++;
          $display("FAIL issue: got instr %h pc %h expected instr %h pc %h at %0t",
                   Instruction, IssuePC, e[31:16], e[15:0], $time);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vectors = 0; miscompares = 0;
    Reset = 1'b1; Run = 1'b0; Stall = 1'b0; Redirect = 1'b0; Target = 16'h0000;
    lat = 0; use_alt = 1'b0; alt_data = 16'h0000;
    #2;
    chk("rst_memreq", {31'd0, MemReq}, 32'd0);
    chk("rst_en", {31'd0, EN}, 32'd0);
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    chk("rst_instr", {16'd0, Instruction}, 32'h0000);
    chk("rst_issuepc", {16'd0, IssuePC}, 32'h0000);
    chk("rst_memaddr", {16'd0, MemAddr}, 32'h0000);

    // 1: back-to-back fetch with 1-cycle memory
    tick(); Reset = 1'b0; Run = 1'b1;
    sample(); chk("t1_idle_busy", {31'd0, Busy}, 32'd0);
    push(16'h1234, 16'h0000); push(16'hA5C3, 16'h0001);
    tick(); sample();
    chk("t1_f0_req", {31'd0, MemReq}, 32'd1);
    chk("t1_f0_addr", {16'd0, MemAddr}, 32'h0000);
    chk("t1_f0_en", {31'd0, EN}, 32'd0);
    tick(); sample();
    chk("t1_i0_en", {31'd0, EN}, 32'd1);
    chk("t1_i0_addr", {16'd0, MemAddr}, 32'h0001);
    tick(); sample();
    chk("t1_f1_en", {31'd0, EN}, 32'd0);
    chk("t1_f1_addr", {16'd0, MemAddr}, 32'h0001);
    tick(); Run = 1'b0; sample();
    chk("t1_i1_en", {31'd0, EN}, 32'd1);
    tick(); sample();
    chk("t1_stop_busy", {31'd0, Busy}, 32'd0);
    chk("t1_stop_addr", {16'd0, MemAddr}, 32'h0002);

    // 2: memory ready after 3 wait cycles; Run drops mid-fetch
    Reset = 1'b1; #2; Reset = 1'b0;
    sample(); chk("t2_rst_addr", {16'd0, MemAddr}, 32'h0000);
    tick(); lat = 3; Run = 1'b1;
    push(16'h1234, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 1) Run = 1'b0;
      sample();
      chk("t2_wait_req", {31'd0, MemReq}, 32'd1);
      chk("t2_wait_addr", {16'd0, MemAddr}, 32'h0000);
      chk("t2_wait_en", {31'd0, EN}, 32'd0);
    end
    tick(); sample();
    chk("t2_issue_en", {31'd0, EN}, 32'd1);
    tick(); sample();
    chk("t2_idle_busy", {31'd0, Busy}, 32'd0);
    chk("t2_pc", {16'd0, MemAddr}, 32'h0001);

    // redirect while idle only moves the PC
    tick(); Redirect = 1'b1; Target = 16'h0000; lat = 0;
    sample(); chk("idle_redir_busy", {31'd0, Busy}, 32'd0);
    tick(); Redirect = 1'b0;
    sample();
    chk("idle_redir_addr", {16'd0, MemAddr}, 32'h0000);
    chk("idle_redir_stay", {31'd0, Busy}, 32'd0);

    // 3: stall for 5 cycles in ISSUE
    push(16'h1234, 16'h0000);
    tick(); Run = 1'b1; Stall = 1'b1;
    tick(); sample();
    chk("t3_fetch_addr", {16'd0, MemAddr}, 32'h0000);
    for (int i = 0; i < 5; i++) begin
      tick(); sample();
      chk("t3_stall_en", {31'd0, EN}, 32'd0);
      chk("t3_stall_req", {31'd0, MemReq}, 32'd0);
      chk("t3_stall_instr", {16'd0, Instruction}, 32'h1234);
    end
    tick(); Stall = 1'b0; Run = 1'b0; sample();
    chk("t3_release_en", {31'd0, EN}, 32'd1);
    tick(); sample();
    chk("t3_after_en", {31'd0, EN}, 32'd0);
    chk("t3_after_addr", {16'd0, MemAddr}, 32'h0001);

    // 4: redirect in the same cycle as MemRdy discards the data
    tick(); Run = 1'b1;
    tick(); Redirect = 1'b1; Target = 16'h0040; use_alt = 1'b1; alt_data = 16'hBEEF;
    sample(); chk("t4_redir_en", {31'd0, EN}, 32'd0);
    push(16'hC09E, 16'h0040);
    tick(); Redirect = 1'b0; use_alt = 1'b0; sample();
    chk("t4_refetch_req", {31'd0, MemReq}, 32'd1);
    chk("t4_refetch_addr", {16'd0, MemAddr}, 32'h0040);
    chk("t4_instr_kept", {16'd0, Instruction}, 32'h1234);
    chk("t4_refetch_en", {31'd0, EN}, 32'd0);
    tick(); Run = 1'b0; sample();
    chk("t4_issue_en", {31'd0, EN}, 32'd1);
    tick(); sample();
    chk("t4_next_addr", {16'd0, MemAddr}, 32'h0041);

    // 5: redirect squashes a stalled instruction
    push(16'hC1DE, 16'h0100);
    tick(); Run = 1'b1; Stall = 1'b1;
    tick();
    tick(); sample(); chk("t5_stall_en", {31'd0, EN}, 32'd0);
    tick(); Redirect = 1'b1; Target = 16'h0100; sample();
    chk("t5_squash_en", {31'd0, EN}, 32'd0);
    tick(); Redirect = 1'b0; Stall = 1'b0; sample();
    chk("t5_fetch_req", {31'd0, MemReq}, 32'd1);
    chk("t5_fetch_addr", {16'd0, MemAddr}, 32'h0100);
    tick(); Run = 1'b0; sample();
    chk("t5_issue_en", {31'd0, EN}, 32'd1);
    tick();

    // 6: PC wrap at 16'hFFFF, then reset in the middle of a fetch
    tick(); Redirect = 1'b1; Target = 16'hFFFF;
    tick(); Redirect = 1'b0; Run = 1'b1; sample();
    chk("t6_idle_addr", {16'd0, MemAddr}, 32'hFFFF);
    push(16'h3F21, 16'hFFFF); push(16'h1234, 16'h0000);
    tick(); sample();
    chk("t6_fetch_addr", {16'd0, MemAddr}, 32'hFFFF);
    tick(); sample();
    chk("t6_issue_pc", {16'd0, IssuePC}, 32'hFFFF);
    chk("t6_wrap_addr", {16'd0, MemAddr}, 32'h0000);
    tick(); sample();
    chk("t6_f0_addr", {16'd0, MemAddr}, 32'h0000);
    tick(); lat = 3; sample();
    chk("t6_i0_en", {31'd0, EN}, 32'd1);
    tick(); sample();
    chk("t6_f1_req", {31'd0, MemReq}, 32'd1);
    chk("t6_f1_addr", {16'd0, MemAddr}, 32'h0001);
    Reset = 1'b1; #1;
    chk("t6_async_req", {31'd0, MemReq}, 32'd0);
    chk("t6_async_addr", {16'd0, MemAddr}, 32'h0000);
    chk("t6_async_busy", {31'd0, Busy}, 32'd0);
    chk("t6_async_en", {31'd0, EN}, 32'd0);
    tick(); tick();
    tick(); Reset = 1'b0; Run = 1'b0; lat = 0;
    tick(); sample();
    chk("t6_post_busy", {31'd0, Busy}, 32'd0);
    chk("t6_post_en", {31'd0, EN}, 32'd0);
    chk("sb_drained", sb_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
